// File: rtl/task_finish_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : task_finish_arbiter_if
// Description : Bundle of the task-finish arbiter signals.
//               - master : the cores and serializer side, which drives
//                          dispatches, finish requests and the output ready.
//               - slave  : the arbiter, which returns the per-core ready
//                          signals, the output event and the status flags.
//               Signals:
//                 core_dispatch      one-cycle dispatch pulse per core
//                 core_finish_valid  per-core finish request
//                 core_finish_ready  per-core finish accept (core in RUN)
//                 out_finish_valid   finish event to the serializer
//                 out_finish_core    core id of the finish event
//                 out_finish_ready   serializer accepts the event
//                 fin_pending_count  number of cores in FIN
//                 all_cores_idle     nothing running, pending or in flight
//                 err_valid          sticky protocol-error flag
//                 err_core           core id of the first error
// Revision    : 1.0 - initial release
// ============================================================================
interface task_finish_arbiter_if #(
  parameter int NUM_CORES   = 10,
  parameter int LOG_N_CORES = $clog2(NUM_CORES)
);
  logic [NUM_CORES-1:0]   core_dispatch;
  logic [NUM_CORES-1:0]   core_finish_valid;
  logic [NUM_CORES-1:0]   core_finish_ready;
  logic                   out_finish_valid;
  logic [LOG_N_CORES-1:0] out_finish_core;
  logic                   out_finish_ready;
  logic [LOG_N_CORES:0]   fin_pending_count;
  logic                   all_cores_idle;
  logic                   err_valid;
  logic [LOG_N_CORES-1:0] err_core;

  modport master (
    output core_dispatch, core_finish_valid, out_finish_ready,
    input  core_finish_ready, out_finish_valid, out_finish_core,
    input  fin_pending_count, all_cores_idle, err_valid, err_core
  );

  modport slave (
    input  core_dispatch, core_finish_valid, out_finish_ready,
    output core_finish_ready, out_finish_valid, out_finish_core,
    output fin_pending_count, all_cores_idle, err_valid, err_core
  );
endinterface
`default_nettype wire

// File: rtl/task_finish_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : task_finish_arbiter
// Description : Tracks each core's task lifecycle (IDLE -> RUN -> FIN) and
//               forwards finish events to the serializer's single finish port,
//               one per cycle, round-robin, through a registered output slot.
//               Also reports sticky protocol errors and the idle status.
// Ports       : clk  - clock
//               rstn - asynchronous active-low reset
//               bus  - task_finish_arbiter_if.slave (see interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module task_finish_arbiter #(
  parameter int NUM_CORES    = 10,
  parameter int LOG_N_CORES  = $clog2(NUM_CORES),
  parameter int IGNORE_CORE0 = 1
) (
  input  wire logic             clk,
  input  wire logic             rstn,
  task_finish_arbiter_if.slave  bus
);

  localparam logic [LOG_N_CORES:0]   c_num_cores = (LOG_N_CORES+1)'(NUM_CORES);
  localparam logic [LOG_N_CORES-1:0] c_last_core = LOG_N_CORES'(NUM_CORES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } core_state_e;

  core_state_e            r_state     [NUM_CORES];
  core_state_e            w_state_nxt [NUM_CORES];

  logic                   r_out_valid;
  logic [LOG_N_CORES-1:0] r_out_core;
  logic [LOG_N_CORES-1:0] r_rr_ptr;
  logic                   r_err_valid;
  logic [LOG_N_CORES-1:0] r_err_core;

  logic [NUM_CORES-1:0]   w_is_run;
  logic [NUM_CORES-1:0]   w_is_fin;
  logic [NUM_CORES-1:0]   w_is_out;
  logic [NUM_CORES-1:0]   w_elig;
  logic [NUM_CORES-1:0]   w_err_vec;
  logic [NUM_CORES-1:0]   w_busy;
  logic                   w_out_hs;
  logic                   w_slot_free;
  logic [LOG_N_CORES-1:0] w_rot_idx [NUM_CORES];
  logic                   w_pick_found;
  logic [LOG_N_CORES-1:0] w_pick_core;
  logic [LOG_N_CORES-1:0] w_rr_nxt;
  logic [LOG_N_CORES-1:0] w_err_idx;
  logic [LOG_N_CORES:0]   w_fin_cnt;

  assign w_out_hs    = r_out_valid & bus.out_finish_ready;
  assign w_slot_free = !r_out_valid | bus.out_finish_ready;

  // Per-core state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CORES; i++) r_state[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) r_state[i] <= w_state_nxt[i];
    end
  end

  // Per-core next state, flags and error detection
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      w_is_run[i]  = (r_state[i] == ST_RUN);
      w_is_fin[i]  = (r_state[i] == ST_FIN);
      w_is_out[i]  = r_out_valid && (r_out_core == LOG_N_CORES'(i));
      // The core already sitting in the output slot must not win again.
      w_elig[i]    = w_is_fin[i] && !w_is_out[i];
      // Dispatch to a busy core and finish from an idle core are both illegal;
      // the offending request is dropped and the state is left untouched.
      w_err_vec[i] = (bus.core_dispatch[i] && (r_state[i] != ST_IDLE)) ||
                     (bus.core_finish_valid[i] && (r_state[i] == ST_IDLE));
      w_busy[i]    = (w_is_run[i] || w_is_fin[i]) &&
                     !((IGNORE_CORE0 != 0) && (i == 0));
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        ST_IDLE: if (bus.core_dispatch[i])     w_state_nxt[i] = ST_RUN;
        ST_RUN:  if (bus.core_finish_valid[i]) w_state_nxt[i] = ST_FIN;
        ST_FIN:  if (w_out_hs && w_is_out[i])  w_state_nxt[i] = ST_IDLE;
        default:                               w_state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  // Candidate order for the round-robin search: rr_ptr, rr_ptr+1, ... mod N
  for (genvar k = 0; k < NUM_CORES; k++) begin : g_rot
    logic [LOG_N_CORES:0] w_sum;
    assign w_sum        = {1'b0, r_rr_ptr} + (LOG_N_CORES+1)'(k);
    assign w_rot_idx[k] = (w_sum >= c_num_cores) ? LOG_N_CORES'(w_sum - c_num_cores)
                                                 : LOG_N_CORES'(w_sum);
  end

  always_comb begin
    w_pick_found = 1'b0;
    w_pick_core  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!w_pick_found && w_elig[w_rot_idx[k]]) begin
        w_pick_found = 1'b1;
        w_pick_core  = w_rot_idx[k];
      end
    end
  end

  assign w_rr_nxt = (w_pick_core == c_last_core) ? '0
                                                 : w_pick_core + LOG_N_CORES'(1);

  // Descending scan so the lowest erroring index is the one left standing.
  always_comb begin
    w_err_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_err_vec[i]) w_err_idx = LOG_N_CORES'(i);
    end
  end

  always_comb begin
    w_fin_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_fin_cnt = w_fin_cnt + (LOG_N_CORES+1)'(w_is_fin[i]);
    end
  end

  // Output slot, round-robin pointer and sticky error capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_core  <= '0;
      r_rr_ptr    <= '0;
      r_err_valid <= 1'b0;
      r_err_core  <= '0;
    end else begin
      if (w_slot_free) begin
        r_out_valid <= w_pick_found;
        if (w_pick_found) begin
          r_out_core <= w_pick_core;
          r_rr_ptr   <= w_rr_nxt;
        end
      end
      if (!r_err_valid && (|w_err_vec)) begin
        r_err_valid <= 1'b1;
        r_err_core  <= w_err_idx;
      end
    end
  end

  assign bus.core_finish_ready = w_is_run;
  assign bus.out_finish_valid  = r_out_valid;
  assign bus.out_finish_core   = r_out_core;
  assign bus.fin_pending_count = w_fin_cnt;
  assign bus.all_cores_idle    = !(|w_busy) && !r_out_valid;
  assign bus.err_valid         = r_err_valid;
  assign bus.err_core          = r_err_core;

endmodule
`default_nettype wire

// File: tb/tb_task_finish_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_task_finish_arbiter
// Description : Self-checking bench for task_finish_arbiter: directed
//               scenarios plus a randomized run compared against a
//               behavioural model of the core lifecycle and arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_task_finish_arbiter;

  localparam int NUM_CORES    = 10;
  localparam int LOG_N_CORES  = 4;
  localparam int IGNORE_CORE0 = 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_FIN  = 2;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  task_finish_arbiter_if #(.NUM_CORES(NUM_CORES), .LOG_N_CORES(LOG_N_CORES)) bus ();

  task_finish_arbiter #(
    .NUM_CORES   (NUM_CORES),
    .LOG_N_CORES (LOG_N_CORES),
    .IGNORE_CORE0(IGNORE_CORE0)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model
  int m_st [NUM_CORES];
  int m_ov, m_oc, m_rr, m_err, m_ec;

  task automatic model_reset();
    for (int i = 0; i < NUM_CORES; i++) m_st[i] = M_IDLE;
    m_ov = 0; m_oc = 0; m_rr = 0; m_err = 0; m_ec = 0;
  endtask

  task automatic model_step(input logic [NUM_CORES-1:0] d,
                            input logic [NUM_CORES-1:0] f, input logic r);
    int nst [NUM_CORES];
    int first_err;
    int winner;
    first_err = -1;
    for (int i = 0; i < NUM_CORES; i++) begin
      nst[i] = m_st[i];
      if (first_err < 0 && ((d[i] && m_st[i] != M_IDLE) || (f[i] && m_st[i] == M_IDLE)))
        first_err = i;
      if (m_st[i] == M_IDLE && d[i]) nst[i] = M_RUN;
      if (m_st[i] == M_RUN && f[i])  nst[i] = M_FIN;
      if (m_st[i] == M_FIN && m_ov != 0 && r && m_oc == i) nst[i] = M_IDLE;
    end
    if (m_ov == 0 || r) begin
      winner = -1;
      for (int k = 0; k < NUM_CORES; k++) begin
        int c;
        c = (m_rr + k) % NUM_CORES;
        if (winner < 0 && m_st[c] == M_FIN && !(m_ov != 0 && m_oc == c)) winner = c;
      end
      if (winner >= 0) begin
        m_ov = 1; m_oc = winner; m_rr = (winner + 1) % NUM_CORES;
      end else begin
        m_ov = 0;
      end
    end
    for (int i = 0; i < NUM_CORES; i++) m_st[i] = nst[i];
    if (m_err == 0 && first_err >= 0) begin
      m_err = 1; m_ec = first_err;
    end
  endtask

  function automatic int model_cnt();
    int n;
    n = 0;
    for (int i = 0; i < NUM_CORES; i++) if (m_st[i] == M_FIN) n++;
    return n;
  endfunction

  function automatic logic model_idle();
    logic idle;
    idle = (m_ov == 0);
    for (int i = 0; i < NUM_CORES; i++)
      if (!(IGNORE_CORE0 != 0 && i == 0) && m_st[i] != M_IDLE) idle = 1'b0;
    return idle;
  endfunction

  function automatic logic [NUM_CORES-1:0] model_ready();
    logic [NUM_CORES-1:0] v;
    for (int i = 0; i < NUM_CORES; i++) v[i] = (m_st[i] == M_RUN);
    return v;
  endfunction

  // One clock: drive inputs, take the edge, update the model, sample at +1
  task automatic tick(input logic [NUM_CORES-1:0] d, input logic [NUM_CORES-1:0] f,
                      input logic r);
    bus.core_dispatch     = d;
    bus.core_finish_valid = f;
    bus.out_finish_ready  = r;
    @(posedge clk);
    model_step(d, f, r);
    #1;
    bus.core_dispatch     = '0;
    bus.core_finish_valid = '0;
    bus.out_finish_ready  = 1'b1;
  endtask

  task automatic apply_reset();
    bus.core_dispatch     = '0;
    bus.core_finish_valid = '0;
    bus.out_finish_ready  = 1'b1;
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_CORES-1:0] bit_of(input int i);
    logic [NUM_CORES-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.out_finish_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.out_finish_valid); end
    checks++; if (bus.out_finish_core !== 4'd0) begin errors++; $display("FAIL reset_core got %0d want 0", bus.out_finish_core); end
    checks++; if (bus.fin_pending_count !== 5'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.fin_pending_count); end
    checks++; if (bus.core_finish_ready !== 10'd0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.core_finish_ready); end
    checks++; if (bus.all_cores_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %0b want 1", bus.all_cores_idle); end
    checks++; if (bus.err_valid !== 1'b0 || bus.err_core !== 4'd0) begin errors++; $display("FAIL reset_err got %0b/%0d want 0/0", bus.err_valid, bus.err_core); end
  endtask

  task automatic test_single();
    tick(bit_of(3), '0, 1'b1);
    checks++; if (bus.core_finish_ready !== bit_of(3)) begin errors++; $display("FAIL single_ready got %b want %b", bus.core_finish_ready, bit_of(3)); end
    checks++; if (bus.all_cores_idle !== 1'b0) begin errors++; $display("FAIL single_busy got %0b want 0", bus.all_cores_idle); end
    tick('0, '0, 1'b1);
    tick('0, bit_of(3), 1'b1);
    checks++; if (bus.fin_pending_count !== 5'd1 || bus.out_finish_valid !== 1'b0) begin errors++; $display("FAIL single_fin got cnt %0d valid %0b want 1/0", bus.fin_pending_count, bus.out_finish_valid); end
    tick('0, '0, 1'b1);
    checks++; if (bus.out_finish_valid !== 1'b1 || bus.out_finish_core !== 4'd3) begin errors++; $display("FAIL single_out got %0b/%0d want 1/3", bus.out_finish_valid, bus.out_finish_core); end
    tick('0, '0, 1'b1);
    checks++; if (bus.out_finish_valid !== 1'b0 || bus.all_cores_idle !== 1'b1 || bus.fin_pending_count !== 5'd0) begin errors++; $display("FAIL single_done got valid %0b idle %0b cnt %0d want 0/1/0", bus.out_finish_valid, bus.all_cores_idle, bus.fin_pending_count); end
  endtask

  task automatic test_simultaneous();
    int exp_core [3];
    int exp_cnt  [3];
    logic [NUM_CORES-1:0] set;
    exp_core = '{7, 1, 4};
    exp_cnt  = '{3, 2, 1};
    // Push core 4 through once so the pointer lands on 5
    tick(bit_of(4), '0, 1'b1);
    tick('0, bit_of(4), 1'b1);
    tick('0, '0, 1'b1);
    tick('0, '0, 1'b1);
    set = bit_of(1) | bit_of(4) | bit_of(7);
    tick(set, '0, 1'b1);
    tick('0, set, 1'b1);
    checks++; if (bus.fin_pending_count !== 5'd3 || bus.out_finish_valid !== 1'b0) begin errors++; $display("FAIL simul_fin got cnt %0d valid %0b want 3/0", bus.fin_pending_count, bus.out_finish_valid); end
    for (int n = 0; n < 3; n++) begin
      tick('0, '0, 1'b1);
      checks++; if (bus.out_finish_valid !== 1'b1 || int'(bus.out_finish_core) != exp_core[n] || int'(bus.fin_pending_count) != exp_cnt[n]) begin
        errors++; $display("FAIL simul_order%0d got %0b/%0d cnt %0d want 1/%0d cnt %0d", n, bus.out_finish_valid, bus.out_finish_core, bus.fin_pending_count, exp_core[n], exp_cnt[n]);
      end
    end
    tick('0, '0, 1'b1);
    checks++; if (bus.out_finish_valid !== 1'b0 || bus.fin_pending_count !== 5'd0) begin errors++; $display("FAIL simul_drain got %0b cnt %0d want 0/0", bus.out_finish_valid, bus.fin_pending_count); end
  endtask

  task automatic test_backpressure();
    tick(bit_of(2), '0, 1'b1);
    tick('0, bit_of(2), 1'b1);
    tick('0, '0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      checks++; if (bus.out_finish_valid !== 1'b1 || bus.out_finish_core !== 4'd2 || bus.core_finish_ready[2] !== 1'b0 || bus.fin_pending_count !== 5'd1) begin
        errors++; $display("FAIL bp_hold%0d got %0b/%0d rdy %0b cnt %0d want 1/2 0 1", n, bus.out_finish_valid, bus.out_finish_core, bus.core_finish_ready[2], bus.fin_pending_count);
      end
      tick('0, '0, (n == 3));
    end
    checks++; if (bus.out_finish_valid !== 1'b0 || bus.fin_pending_count !== 5'd0 || bus.all_cores_idle !== 1'b1) begin errors++; $display("FAIL bp_drain got %0b cnt %0d idle %0b want 0/0/1", bus.out_finish_valid, bus.fin_pending_count, bus.all_cores_idle); end
  endtask

  task automatic test_errors();
    checks++; if (bus.err_valid !== 1'b0) begin errors++; $display("FAIL err_clean got %0b want 0", bus.err_valid); end
    tick('0, bit_of(5), 1'b1);
    checks++; if (bus.err_valid !== 1'b1 || bus.err_core !== 4'd5 || bus.fin_pending_count !== 5'd0) begin errors++; $display("FAIL err_first got %0b/%0d cnt %0d want 1/5/0", bus.err_valid, bus.err_core, bus.fin_pending_count); end
    tick(bit_of(6), '0, 1'b1);
    tick(bit_of(6), '0, 1'b1);
    checks++; if (bus.err_valid !== 1'b1 || bus.err_core !== 4'd5 || bus.core_finish_ready !== bit_of(6)) begin errors++; $display("FAIL err_sticky got %0b/%0d rdy %b want 1/5 %b", bus.err_valid, bus.err_core, bus.core_finish_ready, bit_of(6)); end
    tick('0, bit_of(6), 1'b1);
    tick('0, '0, 1'b1);
    tick('0, '0, 1'b1);
  endtask

  task automatic test_redispatch();
    apply_reset();
    tick(bit_of(0), '0, 1'b1);
    tick('0, bit_of(0), 1'b1);
    tick('0, '0, 1'b0);
    checks++; if (bus.out_finish_valid !== 1'b1 || bus.out_finish_core !== 4'd0) begin errors++; $display("FAIL race_load got %0b/%0d want 1/0", bus.out_finish_valid, bus.out_finish_core); end
    tick(bit_of(0), '0, 1'b1);
    checks++; if (bus.err_valid !== 1'b1 || bus.err_core !== 4'd0 || bus.out_finish_valid !== 1'b0 || bus.fin_pending_count !== 5'd0 || bus.core_finish_ready[0] !== 1'b0) begin
      errors++; $display("FAIL race_err got err %0b/%0d valid %0b cnt %0d rdy0 %0b want 1/0 0 0 0", bus.err_valid, bus.err_core, bus.out_finish_valid, bus.fin_pending_count, bus.core_finish_ready[0]);
    end
    tick(bit_of(0), '0, 1'b1);
    checks++; if (bus.core_finish_ready[0] !== 1'b1) begin errors++; $display("FAIL race_idle got rdy0 %0b want 1", bus.core_finish_ready[0]); end
    tick('0, bit_of(0), 1'b1);
    tick('0, '0, 1'b1);
    tick('0, '0, 1'b1);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    tick(10'b00_0011_1110, '0, 1'b1);
    tick('0, bit_of(1) | bit_of(2) | bit_of(8), 1'b1);
    tick('0, '0, 1'b0);
    checks++; if (bus.out_finish_valid !== 1'b1 || bus.out_finish_core !== 4'd1 || bus.fin_pending_count !== 5'd2 || bus.err_valid !== 1'b1 || bus.err_core !== 4'd8) begin
      errors++; $display("FAIL mid_pre got %0b/%0d cnt %0d err %0b/%0d want 1/1 2 1/8", bus.out_finish_valid, bus.out_finish_core, bus.fin_pending_count, bus.err_valid, bus.err_core);
    end
    #2 rstn = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.out_finish_valid !== 1'b0 || bus.fin_pending_count !== 5'd0 || bus.all_cores_idle !== 1'b1 || bus.err_valid !== 1'b0 || bus.core_finish_ready !== 10'd0) begin
      errors++; $display("FAIL mid_reset got valid %0b cnt %0d idle %0b err %0b rdy %b want 0 0 1 0 0", bus.out_finish_valid, bus.fin_pending_count, bus.all_cores_idle, bus.err_valid, bus.core_finish_ready);
    end
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [NUM_CORES-1:0] d, f;
    logic r;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        d[i] = (m_st[i] == M_IDLE && $urandom_range(99) < 20) || ($urandom_range(999) < 3);
        f[i] = (m_st[i] == M_RUN && $urandom_range(99) < 35) ||
               (m_st[i] == M_FIN && $urandom_range(99) < 30) || ($urandom_range(999) < 3);
      end
      r = ($urandom_range(99) < 70);
      tick(d, f, r);
      checks++; if (bus.out_finish_valid !== (m_ov != 0) || (m_ov != 0 && int'(bus.out_finish_core) != m_oc)) begin
        errors++; $display("FAIL rnd_out cyc %0d got %0b/%0d want %0d/%0d", cyc, bus.out_finish_valid, bus.out_finish_core, m_ov, m_oc);
      end
      checks++; if (int'(bus.fin_pending_count) != model_cnt() || bus.all_cores_idle !== model_idle() || bus.core_finish_ready !== model_ready()) begin
        errors++; $display("FAIL rnd_status cyc %0d got cnt %0d idle %0b rdy %b want %0d %0b %b", cyc, bus.fin_pending_count, bus.all_cores_idle, bus.core_finish_ready, model_cnt(), model_idle(), model_ready());
      end
      checks++; if (bus.err_valid !== (m_err != 0) || (m_err != 0 && int'(bus.err_core) != m_ec)) begin
        errors++; $display("FAIL rnd_err cyc %0d got %0b/%0d want %0d/%0d", cyc, bus.err_valid, bus.err_core, m_err, m_ec);
      end
      // Clear the sticky error now and then so later errors are exercised too
      if (cyc % 150 == 149) apply_reset();
    end
  endtask

  initial begin
    rstn = 1'b0;
    bus.core_dispatch     = '0;
    bus.core_finish_valid = '0;
    bus.out_finish_ready  = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_errors();
    test_redispatch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/task_finish_arbiter.md
Name: task_finish_arbiter

Overview:
- Sits between the cores and the serializer's single finish port (`finished_task_valid` / `finished_task_core`).
- Tracks each core's task lifecycle: IDLE, RUN, FIN.
- Accepts task-finish handshakes from any number of cores in the same cycle.
- Forwards finishes to the serializer one per cycle, round-robin, through a registered output stage.
- Also reports protocol errors and the idle status used for termination checking.

Parameters:
- NUM_CORES, 10, number of cores served. Core 0 is the OCL port.
- LOG_N_CORES, $clog2(NUM_CORES), width of a core index.
- IGNORE_CORE0, 1, when 1, core 0 is excluded from `all_cores_idle`.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- core_dispatch  in  NUM_CORES  one-cycle pulse per core when the serializer hands it a task (the serializer's `s_rvalid`)
- core_finish_valid  in  NUM_CORES  core requests to report task finish
- core_finish_ready  out  NUM_CORES  finish accepted this cycle when valid&ready
- out_finish_valid  out  1  finish event to the serializer
- out_finish_core  out  LOG_N_CORES  core id of the finish event
- out_finish_ready  in  1  serializer accepts the event (tie to 1 if it never stalls)
- fin_pending_count  out  LOG_N_CORES+1  number of cores in FIN state
- all_cores_idle  out  1  no core in RUN/FIN and no output in flight
- err_valid  out  1  sticky protocol-error flag
- err_core  out  LOG_N_CORES  core id of the first error

Behaviour:
- Reset (async, rstn=0): all cores IDLE; out_finish_valid=0; out_finish_core=0; rr_ptr=0; err_valid=0; err_core=0.
  - Consequent outputs after reset: fin_pending_count=0, core_finish_ready=0, all_cores_idle=1.
  - Reset asserted mid-operation discards all pending finishes and in-flight output immediately.
- Per-core state, 2 bits, updated on posedge:
  - IDLE -> RUN on core_dispatch[i].
  - RUN -> FIN on core_finish_valid[i] & core_finish_ready[i].
  - FIN -> IDLE when out_finish_valid & out_finish_ready & out_finish_core==i.
- core_finish_ready[i] = (state[i]==RUN). This is combinational from state only and does not depend on valid.
- Arbitration:
  - Eligible set = cores in FIN, excluding out_finish_core while out_finish_valid=1.
  - The output slot loads when it is free: !out_finish_valid, or out_finish_valid & out_finish_ready.
  - On load, pick the first eligible core at index >= rr_ptr, wrapping modulo NUM_CORES.
  - Set out_finish_valid=1 and out_finish_core=winner, then rr_ptr <= winner+1, wrapping to 0 past NUM_CORES-1.
  - If the slot frees and nothing is eligible, out_finish_valid <= 0.
- Latency: finish handshake in cycle t -> FIN at t+1 -> out_finish_valid at t+2 (if uncontended) -> core IDLE the cycle after the output handshake.
- A core stays FIN until its event is consumed. This guarantees the serializer sees the finish before any redispatch can be legal.
- Output hold: while out_finish_valid & !out_finish_ready, out_finish_valid and out_finish_core are held stable.
- fin_pending_count = popcount of FIN states, including the core in the output register.
- all_cores_idle = no core (excluding core 0 if IGNORE_CORE0) in RUN or FIN, and out_finish_valid=0.
- Errors are sticky until reset. The first error wins; when several cores error in the same cycle, the lowest index is recorded.
  - core_dispatch[i] while state[i]!=IDLE -> error; state unchanged.
  - core_finish_valid[i] while state[i]==IDLE -> error; ignored.
  - core_finish_valid held while FIN is not an error; it simply waits.
- Same-cycle dispatch and output handshake for the same core: the dispatch sees the pre-update state (FIN) -> error; the handshake still completes.

Test Plan:
1. Single task: dispatch core 3 at cycle 0; finish_valid[3] at cycle 2 -> ready[3]=1 at cycle 2; out_finish_valid=1, core=3 at cycle 4; state IDLE, all_cores_idle=1 at cycle 5.
2. Simultaneous finish: cores 1, 4, 7 in RUN all finish in the same cycle with rr_ptr=5 -> outputs on consecutive cycles with cores 7, 1, 4; fin_pending_count goes 3,3,2,1,0.
3. Backpressure: out_finish_ready=0 for 4 cycles with core 2 pending -> out_finish_valid/core=2 held constant; core 2 stays FIN and ready[2]=0; the event drains on the first ready cycle.
4. Protocol errors: finish_valid[5] while core 5 IDLE -> err_valid=1, err_core=5 the next cycle; a later dispatch to a RUN core 6 leaves err_core=5.
5. Redispatch race: core 0 FIN with its event in the output register; assert out_finish_ready and core_dispatch[0] in the same cycle -> err_valid=1, err_core=0; core 0 ends IDLE.
6. Reset mid-operation: 3 cores RUN, 2 FIN, output valid; pulse rstn=0 asynchronously between edges -> out_finish_valid=0 immediately, fin_pending_count=0, all_cores_idle=1, err_valid=0.
